updown_sweep_ctrl: RTL

//  Sequencer for a W-bit up/down counter (direction input s: 1=up, 0=down).

---
 rtl/updown_sweep_ctrl_if.sv | 31 +++
 rtl/updown_sweep_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/updown_sweep_ctrl_if.sv
// Bundle between the sweep controller and its environment: run control,
// configuration, status, and the load/enable/direction/count link to the counter.
interface updown_sweep_ctrl_if #(
   parameter int W  = 4,
   parameter int NW = 4
);
   logic          start;
   logic          abort;
   logic [W-1:0]  lo;
   logic [W-1:0]  hi;
   logic [NW-1:0] sweeps;
   logic [W-1:0]  cnt_val;
   logic          cnt_load;
   logic [W-1:0]  cnt_load_val;
   logic          cnt_en;
   logic          cnt_dir;
   logic          busy;
   logic          done;
   logic          err;
   logic [NW-1:0] sweep_cnt;

   modport master (
      input  start, abort, lo, hi, sweeps, cnt_val,
      output cnt_load, cnt_load_val, cnt_en, cnt_dir, busy, done, err, sweep_cnt
   );

   modport slave (
      output start, abort, lo, hi, sweeps, cnt_val,
      input  cnt_load, cnt_load_val, cnt_en, cnt_dir, busy, done, err, sweep_cnt
   );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for an external up/down counter: loads lo, then
// steps lo->hi->lo for a programmed number of sweeps (0 = until abort).
//
// state | meaning
// idle  | waiting for an accepted start
// load  | counter loads latched lo
// up    | counter steps up toward hi
// down  | counter steps down toward lo
// done  | programmed sweeps finished, one-cycle done pulse
module updown_sweep_ctrl #(
   parameter int W  = 4,
   parameter int NW = 4
) (
   input logic                 clk,
   input logic                 rst,
   updown_sweep_ctrl_if.master bus
);
   localparam logic [2:0] st_idle = 3'd0;
   localparam logic [2:0] st_load = 3'd1;
   localparam logic [2:0] st_up   = 3'd2;
   localparam logic [2:0] st_down = 3'd3;
   localparam logic [2:0] st_done = 3'd4;

   localparam logic [W-1:0]  one_w  = W'(1);
   localparam logic [NW-1:0] one_nw = NW'(1);

   logic [2:0]    state, state_nxt;
   logic          err_q, err_nxt;
   logic          latch_cfg;
   logic          sweep_end;
   logic [W-1:0]  lo_q, hi_q;
   logic [NW-1:0] sweeps_q;
   logic [NW-1:0] sweep_cnt_q;
   logic [NW-1:0] sweep_cnt_inc;

   assign sweep_cnt_inc = sweep_cnt_q + one_nw;

   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      latch_cfg = 1'b0;
      sweep_end = 1'b0;
      case (state)
         st_idle: begin
            if (bus.start && !bus.abort) begin
               if (bus.lo < bus.hi) begin
                  latch_cfg = 1'b1;
                  state_nxt = st_load;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         st_load: state_nxt = bus.abort ? st_idle : st_up;
         st_up: begin
            if (bus.abort) begin
               state_nxt = st_idle;
            end else if (bus.cnt_val >= hi_q) begin
               err_nxt   = 1'b1;
               state_nxt = st_idle;
            end else if (bus.cnt_val == hi_q - one_w) begin
               state_nxt = st_down;
            end
         end
         st_down: begin
            if (bus.abort) begin
               state_nxt = st_idle;
            end else if (bus.cnt_val <= lo_q) begin
               err_nxt   = 1'b1;
               state_nxt = st_idle;
            end else if (bus.cnt_val == lo_q + one_w) begin
               sweep_end = 1'b1;
               // compare against the unsaturated increment; sweeps_q==0 never matches
               if (sweeps_q != '0 && sweep_cnt_inc == sweeps_q) state_nxt = st_done;
               else                                              state_nxt = st_up;
            end
         end
         st_done: state_nxt = st_idle;
         default: state_nxt = st_idle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= st_idle;
         err_q       <= 1'b0;
         lo_q        <= '0;
         hi_q        <= '0;
         sweeps_q    <= '0;
         sweep_cnt_q <= '0;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
         if (latch_cfg) begin
            lo_q        <= bus.lo;
            hi_q        <= bus.hi;
            sweeps_q    <= bus.sweeps;
            sweep_cnt_q <= '0;
         end else if (sweep_end && !(&sweep_cnt_q)) begin
            sweep_cnt_q <= sweep_cnt_inc;
         end
      end
   end

   assign bus.cnt_load     = (state == st_load);
   assign bus.cnt_load_val = lo_q;
   assign bus.cnt_en       = (state == st_up) || (state == st_down);
   assign bus.cnt_dir      = (state == st_up);
   assign bus.busy         = (state == st_load) || (state == st_up) || (state == st_down);
   assign bus.done         = (state == st_done);
   assign bus.err          = err_q;
   assign bus.sweep_cnt    = sweep_cnt_q;
endmodule
